// File: rtl/sound_latch_bridge.sv
// sound_latch_bridge: 68K-to-Z80 sound latch with edge-detected strobes and a periodic Z80 timer interrupt
module sound_latch_bridge #(
  parameter int IRQ_DIV = 512
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       m68k_latch_cs,
  input  logic       m68k_rw,
  input  logic       m68k_lds_n,
  input  logic [7:0] m68k_dout,
  input  logic       z80_cen,
  input  logic       z80_rd_n,
  input  logic       z80_iorq_n,
  input  logic       z80_m1_n,
  input  logic       z80_latch_r_cs,
  input  logic       z80_latch_clr_cs,
  output logic [7:0] z80_latch_dout,
  output logic       z80_int_n,
  output logic [7:0] z80_int_vector,
  output logic       latch_pending,
  output logic       latch_overrun
);
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic [15:0] LAST = 16'(IRQ_DIV - 1);
  state_t state, state_nx;
  logic [3:0] req, low_q, ev;
  logic [15:0] cnt;
  logic [7:0] latch;
  logic wrap_q, wr_ev, rd_ev, clr_ev, ack_ev;
  assign req = {!z80_m1_n && !z80_iorq_n,
                z80_latch_clr_cs && !z80_rd_n && !z80_iorq_n,
                z80_latch_r_cs && !z80_rd_n && !z80_iorq_n,
                m68k_latch_cs && !m68k_rw && !m68k_lds_n};
  assign ev = req & low_q;
  assign {ack_ev, clr_ev, rd_ev, wr_ev} = ev;
  assign z80_latch_dout = latch;
  assign z80_int_n = state == IDLE;
  assign z80_int_vector = 8'hFF;
  always_comb state_nx = wrap_q ? PEND : (state == PEND && ack_ev) ? IDLE : state;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      low_q <= '0;
      cnt <= '0;
      wrap_q <= 1'b0;
      state <= IDLE;
      latch <= '0;
      latch_pending <= 1'b0;
      latch_overrun <= 1'b0;
    end else begin
      low_q <= ~req;
      wrap_q <= z80_cen && cnt == LAST;
      if (z80_cen) cnt <= cnt == LAST ? '0 : cnt + 16'd1;
      state <= state_nx;
      latch <= wr_ev ? m68k_dout : clr_ev ? 8'h00 : latch;
      latch_pending <= wr_ev || (latch_pending && !rd_ev && !clr_ev);
      latch_overrun <= latch_overrun || (wr_ev && latch_pending && !rd_ev && !clr_ev);
    end
endmodule

// File: tb/tb_sound_latch_bridge.sv
// tb_sound_latch_bridge: table, hand-sequence and randomized checks of sound_latch_bridge against a behavioural model
module tb_sound_latch_bridge;
  localparam int DIV = 4;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic m68k_latch_cs = 1'b0, m68k_rw = 1'b1, m68k_lds_n = 1'b1;
  logic [7:0] m68k_dout = 8'h00;
  logic z80_cen = 1'b0, z80_rd_n = 1'b1, z80_iorq_n = 1'b1, z80_m1_n = 1'b1;
  logic z80_latch_r_cs = 1'b0, z80_latch_clr_cs = 1'b0;
  logic [7:0] z80_latch_dout, z80_int_vector;
  logic z80_int_n, latch_pending, latch_overrun;
  int vectors = 0, miscompares = 0;
  logic [7:0] m_latch;
  bit m_pend, m_ovr, m_irq, m_wrap_due;
  int m_ticks;
  bit [3:0] m_seen_low;
  typedef struct {
    logic wr; logic [7:0] d; logic rd, clr, ack;
    logic [7:0] e_latch; logic e_pend, e_ovr, e_int_n;
  } vec_t;
  vec_t tbl[24];
  logic [18:1] exp_int;

  sound_latch_bridge #(.IRQ_DIV(DIV)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .m68k_latch_cs(m68k_latch_cs), .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n), .m68k_dout(m68k_dout),
    .z80_cen(z80_cen), .z80_rd_n(z80_rd_n), .z80_iorq_n(z80_iorq_n), .z80_m1_n(z80_m1_n),
    .z80_latch_r_cs(z80_latch_r_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
    .z80_latch_dout(z80_latch_dout), .z80_int_n(z80_int_n), .z80_int_vector(z80_int_vector),
    .latch_pending(latch_pending), .latch_overrun(latch_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check(string name);
    cmp({name, ".dout"}, 32'(z80_latch_dout), 32'(m_latch));
    cmp({name, ".pend"}, 32'(latch_pending), 32'(m_pend));
    cmp({name, ".ovr"}, 32'(latch_overrun), 32'(m_ovr));
    cmp({name, ".int_n"}, 32'(z80_int_n), 32'(!m_irq));
    cmp({name, ".vec"}, 32'(z80_int_vector), 32'hFF);
  endtask

  task automatic model_reset();
    m_latch = 8'h00; m_pend = 0; m_ovr = 0; m_irq = 0; m_wrap_due = 0; m_ticks = 0; m_seen_low = '0;
  endtask

  task automatic drive(logic wr, logic [7:0] d, logic rd, logic clr, logic ack, logic cen);
    m68k_latch_cs = wr; m68k_rw = !wr; m68k_lds_n = !wr; m68k_dout = d;
    z80_latch_r_cs = rd; z80_latch_clr_cs = clr;
    z80_rd_n = !(rd || clr); z80_iorq_n = !(rd || clr || ack); z80_m1_n = !ack;
    z80_cen = cen;
  endtask

  task automatic step(string name);
    bit [3:0] rq, ev;
    rq = {!z80_m1_n && !z80_iorq_n, z80_latch_clr_cs && !z80_rd_n && !z80_iorq_n,
          z80_latch_r_cs && !z80_rd_n && !z80_iorq_n, m68k_latch_cs && !m68k_rw && !m68k_lds_n};
    ev = rq & m_seen_low;
    m_seen_low = ~rq;
    m_irq = m_wrap_due || (m_irq && !ev[3]);
    if (z80_cen) m_ticks++;
    m_wrap_due = z80_cen && (m_ticks % DIV == 0);
    if (ev[0]) begin
      m_ovr = m_ovr || (m_pend && !ev[1] && !ev[2]);
      m_latch = m68k_dout;
      m_pend = 1;
    end else if (ev[2]) begin
      m_latch = 8'h00;
      m_pend = 0;
    end else if (ev[1]) m_pend = 0;
    @(posedge clk_sys); #1;
    check(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2 check("reset_async");
    @(posedge clk_sys); #1;
    check("reset_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

    // table: latch protocol with the timer stopped
    #1 do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr, tbl[i].ack, 1'b0);
      step($sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.latch", i), 32'(z80_latch_dout), 32'(tbl[i].e_latch));
      cmp($sformatf("tbl%0d.pend", i), 32'(latch_pending), 32'(tbl[i].e_pend));
      cmp($sformatf("tbl%0d.ovr", i), 32'(latch_overrun), 32'(tbl[i].e_ovr));
      cmp($sformatf("tbl%0d.int_n", i), 32'(z80_int_n), 32'(tbl[i].e_int_n));
    end

    // timer: first fall, ack, refall, ack on wrap, unqueued second wrap, single ack release
    exp_int = 18'b1_000000000_1110_1111;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, e == 6 || e == 13 || e == 18, 1'b1);
      step($sformatf("tmr%0d", e));
      cmp($sformatf("tmr%0d.int_n_const", e), 32'(z80_int_n), 32'(exp_int[e]));
    end

    // async reset from a busy state, then a strobe held across reset release
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    step("pre_idle");
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1); step("pre_w11");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); step("pre_idle2");
    drive(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1); step("pre_w7e");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && z80_int_n !== 1'b0; i++) step("pre_wait");
    cmp("pre.int_n", 32'(z80_int_n), 32'h0);
    cmp("pre.ovr", 32'(latch_overrun), 32'h1);
    cmp("pre.latch", 32'(z80_latch_dout), 32'h7E);
    #3 reset_n = 1'b0;
    model_reset();
    drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 cmp("arst.int_n", 32'(z80_int_n), 32'h1);
    cmp("arst.ovr", 32'(latch_overrun), 32'h0);
    cmp("arst.pend", 32'(latch_pending), 32'h0);
    cmp("arst.latch", 32'(z80_latch_dout), 32'h00);
    @(posedge clk_sys); #1;
    check("arst_hold");
    reset_n = 1'b1;
    step("held1");
    step("held2");
    cmp("held.latch", 32'(z80_latch_dout), 32'h00);
    cmp("held.pend", 32'(latch_pending), 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step("held_rel");
    drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0); step("held_re");
    cmp("rearm.latch", 32'(z80_latch_dout), 32'hAB);
    cmp("rearm.pend", 32'(latch_pending), 32'h1);

    // randomized traffic against the model
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      m68k_latch_cs = $urandom_range(0, 3) == 0;
      m68k_rw = $urandom_range(0, 3) == 0;
      m68k_lds_n = $urandom_range(0, 3) == 0;
      m68k_dout = 8'($urandom);
      z80_cen = $urandom_range(0, 1) == 0;
      z80_iorq_n = $urandom_range(0, 2) != 0;
      z80_rd_n = $urandom_range(0, 1) == 0;
      z80_m1_n = $urandom_range(0, 3) != 0;
      z80_latch_r_cs = $urandom_range(0, 3) == 0;
      z80_latch_clr_cs = $urandom_range(0, 5) == 0;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sound_latch_bridge.md
SOUND_LATCH_BRIDGE -- requirements
Module: sound_latch_bridge

Interface
REQ-001 Parameter IRQ_DIV, default 512: number of z80_cen pulses between Z80 timer interrupts; legal range 2..65535.
REQ-002 clk_sys  in  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 m68k_latch_cs  in  1  decoded 68K sound-latch select, 0x02600c/0x04600c; gated by AS.
REQ-005 m68k_rw  in  1  68K bus direction; 1 = read, 0 = write.
REQ-006 m68k_lds_n  in  1  68K lower data strobe, active-low.
REQ-007 m68k_dout  in  8  68K write data, low byte.
REQ-008 z80_cen  in  1  one-clk_sys-wide Z80 clock-enable pulse.
REQ-009 z80_rd_n  in  1  Z80 read strobe, active-low.
REQ-010 z80_iorq_n  in  1  Z80 IORQ, active-low.
REQ-011 z80_m1_n  in  1  Z80 M1, active-low.
REQ-012 z80_latch_r_cs  in  1  decoded Z80 I/O port 0x06 read select.
REQ-013 z80_latch_clr_cs  in  1  decoded Z80 I/O port 0x04 read select; clears the latch.
REQ-014 z80_latch_dout  out  8  latch contents to the Z80 data bus mux.
REQ-015 z80_int_n  out  1  Z80 maskable interrupt request, active-low.
REQ-016 z80_int_vector  out  8  interrupt-acknowledge data; constant 0xFF (RST 38h).
REQ-017 latch_pending  out  1  1 = latch written by 68K and not yet consumed by Z80.
REQ-018 latch_overrun  out  1  sticky; 1 = 68K overwrote an unconsumed latch.

Function
REQ-019 Write event: wr_req = m68k_latch_cs & !m68k_rw & !m68k_lds_n, registered; the event fires on the clk_sys cycle where wr_req is 1 and its registered copy is 0, giving exactly one event per strobe assertion regardless of duration.
REQ-020 On a write event, the latch loads m68k_dout and latch_pending is set to 1; both are visible on outputs the cycle after the event (1-cycle latency).
REQ-021 Write event while latch_pending = 1: latch_overrun is set to 1 and the latch is overwritten with the new data.
REQ-022 Read event: rd_req = z80_latch_r_cs & !z80_rd_n & !z80_iorq_n, edge-detected as in REQ-019; it clears latch_pending and leaves the latch data unchanged.
REQ-023 Clear event: clr_req = z80_latch_clr_cs & !z80_rd_n & !z80_iorq_n, edge-detected; it sets the latch to 0x00 and latch_pending to 0.
REQ-024 z80_latch_dout is driven directly from the latch register at all times, with no combinational path from inputs.
REQ-025 Write event in the same cycle as a read or clear event: the write wins; latch = new data, latch_pending = 1, and latch_overrun is unchanged.
REQ-026 Timer: a counter advances 0..IRQ_DIV-1 only on cycles with z80_cen = 1, and wraps to 0 after reaching IRQ_DIV-1.
REQ-027 On the wrap cycle, z80_int_n goes to 0 on the next clk_sys edge and is held until acknowledged.
REQ-028 Acknowledge: ack_req = !z80_m1_n & !z80_iorq_n, edge-detected; on an ack event, z80_int_n returns to 1.
REQ-029 Ack event in the same cycle as a timer wrap: the interrupt stays asserted (z80_int_n = 0).
REQ-030 Timer wrap while z80_int_n is already 0: no change; interrupts do not queue or count.
REQ-031 An ack event while z80_int_n = 1 is ignored.
REQ-032 The interrupt state machine has two states, IDLE (z80_int_n = 1) and PEND (z80_int_n = 0):
- IDLE -> PEND on wrap.
- PEND -> IDLE on ack without simultaneous wrap.
REQ-033 z80_int_vector is 0xFF constantly.

Reset
REQ-034 While reset_n = 0, the following hold:
- latch = 0x00;
- latch_pending = 0 and latch_overrun = 0;
- z80_int_n = 1 and the state machine is in IDLE;
- timer counter = 0;
- all edge-detect registers = 0.
REQ-035 Reset asserted mid-strobe: after release, a strobe still held high produces no event until it deasserts and reasserts.
REQ-036 latch_overrun clears only on reset.

Verification
REQ-037 68K writes 0x5A with LDS held for 6 cycles -> latch = 0x5A, latch_pending = 1 one cycle after the first strobe cycle; exactly one event; latch_overrun = 0.
REQ-038 Writes 0x11 then 0x22 with no Z80 read in between -> latch = 0x22, latch_pending = 1, latch_overrun = 1; a subsequent port-0x06 read -> latch_pending = 0, z80_latch_dout = 0x22.
REQ-039 Latch = 0x33 pending; a port-0x04 read and a 68K write of 0x44 land in the same cycle -> latch = 0x44, latch_pending = 1.
REQ-040 IRQ_DIV = 4 with z80_cen every cycle -> z80_int_n falls 5 cycles after reset release; M1+IORQ ack -> z80_int_n = 1 next cycle; it falls again 4 cycles after the prior wrap.
REQ-041 Ack coincides with a wrap -> z80_int_n stays 0; a second wrap with no ack -> z80_int_n stays 0, and a single ack releases it.
REQ-042 reset_n pulsed low for 1 cycle while z80_int_n = 0, latch_overrun = 1, and the latch holds 0x7E -> all outputs return to their REQ-034 values asynchronously.
